// File: rtl/bus_initiator_if.sv
// Valid/ready/grant handshake bus between an initiator and a responder.
// Carries the arbiter request/grant pair and the word handshake.
//   master : drives bus_req, valid, data, addr; receives grant, ready
//   slave  : receives bus_req, valid, data, addr; drives grant, ready
interface bus_initiator_if #(
  parameter int D_WIDTH = 31,
  parameter int A_WIDTH = 8
);
  logic               bus_req;
  logic               grant;
  logic               valid;
  logic               ready;
  logic [D_WIDTH-1:0] data;
  logic [A_WIDTH-1:0] addr;

  modport master (output bus_req, valid, data, addr, input grant, ready);
  modport slave  (input bus_req, valid, data, addr, output grant, ready);
endinterface

// File: rtl/bus_initiator.sv
// Initiator end of the valid/ready/grant handshake bus.
// Local requests are queued in a small circular FIFO; the FSM requests the
// bus, waits for grant and presents each word with valid held until ready.
//
// Optional feature macro: BUS_INIT_TIMEOUT_EN
//   defined   : XFER aborts after TIMEOUT cycles without ready, the head word
//               is discarded and err pulses for one cycle.
//   undefined : no timeout counter, err tied low, XFER waits indefinitely.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready  local push handshake
//   req_data, req_addr   local word to queue
//   bus                  handshake bus, master side
//   count                FIFO occupancy
//   err                  one-cycle timeout pulse
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | FIFO empty or just drained, bus not requested
// WAIT_GNT | bus_req high, waiting for grant
// XFER     | valid high with head word, waiting for ready
module bus_initiator #(
  parameter int D_WIDTH = 31,
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [D_WIDTH-1:0]     req_data,
  input  logic [A_WIDTH-1:0]     req_addr,
  bus_initiator_if.master        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, XFER} state_t;

  state_t             state_q;
  logic               bus_req_q;
  logic               valid_q;
  logic [D_WIDTH-1:0] data_q;
  logic [A_WIDTH-1:0] addr_q;

  logic [D_WIDTH-1:0] mem_data [DEPTH];
  logic [A_WIDTH-1:0] mem_addr [DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW-1:0]      rd_ptr_nxt;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;

  logic push;
  logic pop;
  logic xfer_done;
  logic tmo_hit;
  logic remain;

  assign req_ready  = (count_q != CW'(DEPTH));
  assign push       = req_valid && req_ready;
  assign xfer_done  = (state_q == XFER) && bus.ready;
  assign pop        = xfer_done || tmo_hit;
  assign rd_ptr_nxt = rd_ptr_q + PW'(1);
  // Occupancy after the pop at this edge; a same-cycle push is not yet
  // readable, so it is picked up on the next pass through IDLE.
  assign remain     = (count_q > CW'(1));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= req_data;
      mem_addr[wr_ptr_q] <= req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_req_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q   <= WAIT_GNT;
            bus_req_q <= 1'b1;
          end
        end
        WAIT_GNT: begin
          if (bus.grant) begin
            state_q <= XFER;
            valid_q <= 1'b1;
            data_q  <= mem_data[rd_ptr_q];
            addr_q  <= mem_addr[rd_ptr_q];
          end
        end
        XFER: begin
          if (bus.ready) begin
            if (remain && bus.grant) begin
              // back-to-back: next head is one past the word just popped
              data_q <= mem_data[rd_ptr_nxt];
              addr_q <= mem_addr[rd_ptr_nxt];
            end else if (remain) begin
              state_q <= WAIT_GNT;
              valid_q <= 1'b0;
            end else begin
              state_q   <= IDLE;
              valid_q   <= 1'b0;
              bus_req_q <= 1'b0;
            end
          end else if (tmo_hit) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            bus_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          valid_q   <= 1'b0;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_INIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] tmo_cnt_q;
  logic          err_q;

  // Down-counter reloaded outside XFER and on every transfer; reaching zero
  // without ready marks the TIMEOUT-th consecutive stalled XFER cycle.
  assign tmo_hit = (state_q == XFER) && !bus.ready && (tmo_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= TW'(TIMEOUT - 1);
      err_q     <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if ((state_q != XFER) || xfer_done) begin
        tmo_cnt_q <= TW'(TIMEOUT - 1);
      end else if (tmo_cnt_q != '0) begin
        tmo_cnt_q <= tmo_cnt_q - TW'(1);
      end
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign bus.bus_req = bus_req_q;
  assign bus.valid   = valid_q;
  assign bus.data    = data_q;
  assign bus.addr    = addr_q;
  assign count       = count_q;

endmodule

// File: tb/tb_bus_initiator.sv
module tb_bus_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [30:0] req_data;
  logic [7:0]  req_addr;
  logic [2:0]  count;
  logic        err;

  logic grant_tb;
  logic reg_mode;
  logic ready_force;
  logic ready_reg;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [38:0] sb [$];
  int          acc_cyc [$];

  bus_initiator_if #(.D_WIDTH(31), .A_WIDTH(8)) bus ();

  bus_initiator #(.D_WIDTH(31), .A_WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .bus       (bus.master),
    .count     (count),
    .err       (err)
  );

  assign bus.grant = grant_tb;
  assign bus.ready = reg_mode ? ready_reg : ready_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // registered-ready responder: ready follows valid one cycle later
  always @(posedge clk or posedge rst) begin
    if (rst) ready_reg <= 1'b0;
    else     ready_reg <= bus.valid;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // a word is accepted at the posedge following a negedge with valid && ready
  always @(negedge clk) begin
    if (!rst && bus.valid && bus.ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else                chk("bus_word", {25'd0, bus.addr, bus.data}, {25'd0, sb.pop_front()});
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] a, input logic [30:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    if (req_ready) sb.push_back({a, d});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int hold;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; req_addr = '0;
    grant_tb = 1'b0; reg_mode = 1'b1; ready_force = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",     64'(bus.valid),   64'd0);
    chk("rst_bus_req",   64'(bus.bus_req), 64'd0);
    chk("rst_count",     64'(count),       64'd0);
    chk("rst_req_ready", 64'(req_ready),   64'd1);
    chk("rst_err",       64'(err),         64'd0);
    rst = 1'b0;
    tick();

    // single word, grant high, registered-ready responder
    grant_tb = 1'b1;
    n0 = acc_cyc.size();
    push_one(8'h10, 31'h5A5A);               // edge N
    chk("sw_count_n",    64'(count),       64'd1);
    chk("sw_bus_req_n",  64'(bus.bus_req), 64'd0);
    tick();                                  // N+1
    chk("sw_bus_req_n1", 64'(bus.bus_req), 64'd1);
    chk("sw_valid_n1",   64'(bus.valid),   64'd0);
    tick();                                  // N+2
    chk("sw_valid_n2",   64'(bus.valid),   64'd1);
    chk("sw_addr",       64'(bus.addr),    64'h10);
    chk("sw_data",       64'(bus.data),    64'h5A5A);
    tick();                                  // N+3
    chk("sw_valid_n3",   64'(bus.valid),   64'd1);
    tick();                                  // N+4: transfer
    chk("sw_accepts",    64'(acc_cyc.size() - n0), 64'd1);
    chk("sw_valid_end",  64'(bus.valid),   64'd0);
    chk("sw_bus_req_end",64'(bus.bus_req), 64'd0);
    chk("sw_count_end",  64'(count),       64'd0);
    repeat (2) tick();

    // fill with grant low, then back-to-back drain
    grant_tb = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(8'(8'h20 + i), 31'(i));
    chk("fill_count",     64'(count),     64'd4);
    chk("fill_req_ready", 64'(req_ready), 64'd0);
    push_one(8'h25, 31'd5);                  // refused
    chk("fill_refused",   64'(count),     64'd4);
    chk("fill_sb_size",   64'(sb.size()), 64'd4);
    chk("fill_bus_req",   64'(bus.bus_req), 64'd1);
    chk("fill_valid",     64'(bus.valid),   64'd0);
    n0 = acc_cyc.size();
    grant_tb = 1'b1;
    begin
      int n = 0;
      tick();
      while ((count != 0 || bus.valid) && n < 50) begin
        tick();
        n++;
      end
      chk("drain_done", 64'(n < 50), 64'd1);
    end
    chk("drain_accepts", 64'(acc_cyc.size() - n0), 64'd4);
    if (acc_cyc.size() >= n0 + 4)
      chk("drain_b2b", 64'(acc_cyc[n0+3] - acc_cyc[n0]), 64'd3);
    repeat (2) tick();

    // grant drop while valid and not ready
    reg_mode = 1'b0; ready_force = 1'b0; grant_tb = 1'b1;
    push_one(8'h31, 31'h111);
    push_one(8'h32, 31'h222);
    wait_valid("gd_wait_valid");
    grant_tb = 1'b0;
    repeat (3) tick();
    chk("gd_valid_hold", 64'(bus.valid),   64'd1);
    chk("gd_data_hold",  64'(bus.data),    64'h111);
    chk("gd_addr_hold",  64'(bus.addr),    64'h31);
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    chk("gd_valid_wait", 64'(bus.valid),   64'd0);
    chk("gd_bus_req",    64'(bus.bus_req), 64'd1);
    chk("gd_count",      64'(count),       64'd1);
    repeat (2) tick();
    chk("gd_still_idle", 64'(bus.valid),   64'd0);
    grant_tb = 1'b1;
    tick();
    chk("gd_resume",     64'(bus.valid),   64'd1);
    chk("gd_data2",      64'(bus.data),    64'h222);
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    chk("gd_end_valid",  64'(bus.valid),   64'd0);
    chk("gd_end_req",    64'(bus.bus_req), 64'd0);
    repeat (2) tick();

    // timeout behaviour
    push_one(8'h40, 31'h4444);
    wait_valid("to_wait_valid");
`ifdef BUS_INIT_TIMEOUT_EN
    repeat (15) tick();
    chk("to_valid_15",  64'(bus.valid), 64'd1);
    chk("to_err_15",    64'(err),       64'd0);
    tick();
    chk("to_err_pulse", 64'(err),       64'd1);
    chk("to_valid_off", 64'(bus.valid), 64'd0);
    chk("to_count",     64'(count),     64'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
    chk("to_err_once",  64'(err),       64'd0);
`else
    hold = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.valid && !err) hold++;
    end
    chk("nto_hold100", 64'(hold), 64'd100);
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    chk("nto_done",    64'(bus.valid), 64'd0);
`endif
    repeat (2) tick();

    // reset mid-XFER
    push_one(8'h50, 31'h5555);
    wait_valid("rx_wait_valid");
    rst = 1'b1;
    #1;
    chk("rx_valid",   64'(bus.valid),   64'd0);
    chk("rx_bus_req", 64'(bus.bus_req), 64'd0);
    chk("rx_count",   64'(count),       64'd0);
    chk("rx_data",    64'(bus.data),    64'd0);
    chk("rx_addr",    64'(bus.addr),    64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    push_one(8'h60, 31'h6666);               // edge N
    tick();                                  // N+1
    chk("rx_valid_n1", 64'(bus.valid), 64'd0);
    tick();                                  // N+2
    chk("rx_valid_n2", 64'(bus.valid), 64'd1);
    chk("rx_data_n2",  64'(bus.data),  64'h6666);
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    chk("rx_idle",     64'(bus.valid), 64'd0);
    repeat (2) tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
